// File: rtl/pl_fetch_unit.sv
// Instruction fetch stage: issues one-cycle-latency memory reads, buffers up to two
// responses while decode stalls, and flushes on execute-stage redirects.
module pl_fetch_unit #(
   parameter int PROG_CTR_WID = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    stall,
   input  logic                    branch_taken_reg,
   input  logic [PROG_CTR_WID-1:0] branch_target,
   output logic                    imem_rd_en,
   output logic [PROG_CTR_WID-1:0] imem_addr,
   input  logic [15:0]             imem_rdata,
   output logic [15:0]             instr_out,
   output logic                    instr_valid,
   output logic [PROG_CTR_WID-1:0] instr_pc,
   output logic [1:0]              fsm_state
);

   localparam logic [1:0] RST_WAIT = 2'd0;
   localparam logic [1:0] RUN      = 2'd1;
   localparam logic [1:0] FLUSH    = 2'd2;
   localparam logic [PROG_CTR_WID-1:0] PC_ONE = PROG_CTR_WID'(1);

   logic [1:0]              state;
   logic [PROG_CTR_WID-1:0] pc;
   logic [15:0]             fifo_instr [2];
   logic [PROG_CTR_WID-1:0] fifo_addr  [2];
   logic [1:0]              fifo_count;
   logic                    inflight;
   logic [PROG_CTR_WID-1:0] inflight_addr;
   logic                    issue;
   logic                    capture;

   // Memory handshake: a request is imem_rd_en=1 with imem_addr in cycle N; there is
   // no backpressure, and imem_rdata carries its data throughout cycle N+1.
   // Issue only while the FIFO plus the in-flight slot can absorb one more response.
   assign issue = !rst && (state == RUN) && !branch_taken_reg &&
                  (({1'b0, fifo_count} + {2'b00, inflight}) <= 3'd1);
   assign capture    = inflight && !branch_taken_reg;
   assign imem_rd_en = issue;
   assign imem_addr  = issue ? pc : '0;
   assign fsm_state  = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= RST_WAIT;
         pc            <= '0;
         fifo_count    <= 2'd0;
         inflight      <= 1'b0;
         inflight_addr <= '0;
         instr_out     <= 16'h0000;
         instr_valid   <= 1'b0;
         instr_pc      <= '0;
      end else if (branch_taken_reg) begin
         // Redirect wins over stall; clearing inflight drops the response now on the bus.
         state       <= FLUSH;
         pc          <= branch_target;
         fifo_count  <= 2'd0;
         inflight    <= 1'b0;
         instr_out   <= 16'h0000;
         instr_valid <= 1'b0;
         instr_pc    <= '0;
      end else begin
         if (state != RUN) state <= RUN;
         inflight <= issue;
         if (issue) begin
            pc            <= pc + PC_ONE;
            inflight_addr <= pc;
         end
         if (!stall) begin
            if (fifo_count != 2'd0) begin
               instr_out   <= fifo_instr[0];
               instr_pc    <= fifo_addr[0];
               instr_valid <= 1'b1;
               if (fifo_count == 2'd2) begin
                  fifo_instr[0] <= fifo_instr[1];
                  fifo_addr[0]  <= fifo_addr[1];
                  if (capture) begin
                     fifo_instr[1] <= imem_rdata;
                     fifo_addr[1]  <= inflight_addr;
                  end
               end else if (capture) begin
                  fifo_instr[0] <= imem_rdata;
                  fifo_addr[0]  <= inflight_addr;
               end
               if (!capture) fifo_count <= fifo_count - 2'd1;
            end else if (capture) begin
               instr_out   <= imem_rdata;
               instr_pc    <= inflight_addr;
               instr_valid <= 1'b1;
            end else begin
               instr_out   <= 16'h0000;
               instr_pc    <= '0;
               instr_valid <= 1'b0;
            end
         end else if (capture) begin
            if (fifo_count == 2'd0) begin
               fifo_instr[0] <= imem_rdata;
               fifo_addr[0]  <= inflight_addr;
            end else begin
               fifo_instr[1] <= imem_rdata;
               fifo_addr[1]  <= inflight_addr;
            end
            fifo_count <= fifo_count + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_pl_fetch_unit.sv
// Directed bench for pl_fetch_unit: a cycle-by-cycle vector table, then a wrap-around
// sequence checked against an expected queue.
module tb_pl_fetch_unit;

   localparam int W = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          stall = 1'b0;
   logic          branch_taken_reg = 1'b0;
   logic [W-1:0]  branch_target = '0;
   logic          imem_rd_en;
   logic [W-1:0]  imem_addr;
   logic [15:0]   imem_rdata = 16'h0000;
   logic [15:0]   instr_out;
   logic          instr_valid;
   logic [W-1:0]  instr_pc;
   logic [1:0]    fsm_state;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic         rst;
      logic         stall;
      logic         br;
      logic [W-1:0] tgt;
      logic         rd_en;
      logic [W-1:0] addr;
      logic         valid;
      logic [15:0]  instr;
      logic [W-1:0] pc;
   } vec_t;

   vec_t vecs[$];
   logic [15:0] exp_q[$];
   logic [W-1:0] exp_pc_q[$];

   pl_fetch_unit #(.PROG_CTR_WID(W)) dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken_reg(branch_taken_reg),
      .branch_target(branch_target), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .instr_out(instr_out), .instr_valid(instr_valid),
      .instr_pc(instr_pc), .fsm_state(fsm_state)
   );

   // clock / memory model
   always #5 clk = ~clk;

   always @(posedge clk)
      imem_rdata <= imem_rd_en ? (16'h1000 + {6'b0, imem_addr}) : 16'hdead;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic tick(input logic r, input logic s, input logic b, input logic [W-1:0] t);
      @(posedge clk);
      #1;
      rst = r; stall = s; branch_taken_reg = b; branch_target = t;
      @(negedge clk);
   endtask

   task automatic chk(input string name, input int cyc, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic s, input logic b, input logic [W-1:0] t,
                      input logic rd, input logic [W-1:0] a, input logic v,
                      input logic [15:0] i, input logic [W-1:0] p);
      vec_t x;
      x.rst = r; x.stall = s; x.br = b; x.tgt = t;
      x.rd_en = rd; x.addr = a; x.valid = v; x.instr = i; x.pc = p;
      vecs.push_back(x);
   endtask

   initial begin
      //   rst stl br tgt        rd  addr       v  instr     pc
      add(1, 0, 0, 10'h000,  0, 10'h000,  0, 16'h0000, 10'h000); // 0 reset
      add(1, 0, 0, 10'h000,  0, 10'h000,  0, 16'h0000, 10'h000); // 1
      add(0, 0, 0, 10'h000,  0, 10'h000,  0, 16'h0000, 10'h000); // 2 RST_WAIT
      add(0, 0, 0, 10'h000,  1, 10'h000,  0, 16'h0000, 10'h000); // 3 first fetch
      add(0, 0, 0, 10'h000,  1, 10'h001,  0, 16'h0000, 10'h000); // 4
      add(0, 0, 0, 10'h000,  1, 10'h002,  1, 16'h1000, 10'h000); // 5 first valid
      add(0, 0, 0, 10'h000,  1, 10'h003,  1, 16'h1001, 10'h001); // 6
      add(0, 0, 0, 10'h000,  1, 10'h004,  1, 16'h1002, 10'h002); // 7
      add(0, 1, 0, 10'h000,  1, 10'h005,  1, 16'h1003, 10'h003); // 8 stall x5
      add(0, 1, 0, 10'h000,  0, 10'h000,  1, 16'h1003, 10'h003); // 9
      add(0, 1, 0, 10'h000,  0, 10'h000,  1, 16'h1003, 10'h003); // 10
      add(0, 1, 0, 10'h000,  0, 10'h000,  1, 16'h1003, 10'h003); // 11
      add(0, 1, 0, 10'h000,  0, 10'h000,  1, 16'h1003, 10'h003); // 12
      add(0, 0, 0, 10'h000,  0, 10'h000,  1, 16'h1003, 10'h003); // 13 release
      add(0, 0, 0, 10'h000,  1, 10'h006,  1, 16'h1004, 10'h004); // 14 buffered
      add(0, 0, 0, 10'h000,  1, 10'h007,  1, 16'h1005, 10'h005); // 15 buffered
      add(0, 0, 0, 10'h000,  1, 10'h008,  1, 16'h1006, 10'h006); // 16
      add(0, 0, 0, 10'h000,  1, 10'h009,  1, 16'h1007, 10'h007); // 17
      add(0, 1, 0, 10'h000,  1, 10'h00a,  1, 16'h1008, 10'h008); // 18 fill FIFO
      add(0, 1, 0, 10'h000,  0, 10'h000,  1, 16'h1008, 10'h008); // 19
      add(0, 1, 1, 10'h155,  0, 10'h000,  1, 16'h1008, 10'h008); // 20 branch T
      add(0, 0, 0, 10'h000,  0, 10'h000,  0, 16'h0000, 10'h000); // 21 FLUSH
      add(0, 0, 0, 10'h000,  1, 10'h155,  0, 16'h0000, 10'h000); // 22 T+2
      add(0, 0, 0, 10'h000,  1, 10'h156,  0, 16'h0000, 10'h000); // 23
      add(0, 0, 0, 10'h000,  1, 10'h157,  1, 16'h1155, 10'h155); // 24 T+4
      add(0, 0, 0, 10'h000,  1, 10'h158,  1, 16'h1156, 10'h156); // 25
      add(0, 0, 1, 10'h020,  0, 10'h000,  1, 16'h1157, 10'h157); // 26 branch
      add(0, 0, 1, 10'h040,  0, 10'h000,  0, 16'h0000, 10'h000); // 27 branch again
      add(0, 0, 0, 10'h000,  0, 10'h000,  0, 16'h0000, 10'h000); // 28
      add(0, 0, 0, 10'h000,  1, 10'h040,  0, 16'h0000, 10'h000); // 29
      add(0, 0, 0, 10'h000,  1, 10'h041,  0, 16'h0000, 10'h000); // 30
      add(0, 0, 0, 10'h000,  1, 10'h042,  1, 16'h1040, 10'h040); // 31
      add(0, 0, 0, 10'h000,  1, 10'h043,  1, 16'h1041, 10'h041); // 32
      add(0, 1, 0, 10'h000,  1, 10'h044,  1, 16'h1042, 10'h042); // 33 fill FIFO
      add(0, 1, 0, 10'h000,  0, 10'h000,  1, 16'h1042, 10'h042); // 34
      add(1, 1, 0, 10'h000,  0, 10'h000,  1, 16'h1042, 10'h042); // 35 rst pulse
      add(0, 0, 0, 10'h000,  0, 10'h000,  0, 16'h0000, 10'h000); // 36
      add(0, 0, 0, 10'h000,  1, 10'h000,  0, 16'h0000, 10'h000); // 37
      add(0, 0, 0, 10'h000,  1, 10'h001,  0, 16'h0000, 10'h000); // 38
      add(0, 0, 0, 10'h000,  1, 10'h002,  1, 16'h1000, 10'h000); // 39
      add(0, 0, 0, 10'h000,  1, 10'h003,  1, 16'h1001, 10'h001); // 40

      foreach (vecs[i]) begin
         tick(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt);
         chk("rd_en", i, {15'b0, imem_rd_en}, {15'b0, vecs[i].rd_en});
         if (vecs[i].rd_en) chk("imem_addr", i, {6'b0, imem_addr}, {6'b0, vecs[i].addr});
         chk("instr_valid", i, {15'b0, instr_valid}, {15'b0, vecs[i].valid});
         chk("instr_out", i, instr_out, vecs[i].instr);
         chk("instr_pc", i, {6'b0, instr_pc}, {6'b0, vecs[i].pc});
      end

      // wrap-around: redirect to 10'h3FE and expect a gap-free stream across 0
      for (int k = 0; k < 4; k++) begin
         logic [W-1:0] a;
         a = W'(10'h3fe + k);
         exp_pc_q.push_back(a);
         exp_q.push_back(16'h1000 + {6'b0, a});
      end
      tick(0, 0, 1, 10'h3fe);
      begin
         logic         started;
         logic         have_prev;
         logic [W-1:0] prev_addr;
         started = 1'b0;
         have_prev = 1'b0;
         prev_addr = '0;
         for (int c = 0; c < 12 && exp_q.size() != 0; c++) begin
            tick(0, 0, 0, 10'h000);
            if (imem_rd_en) begin
               if (have_prev) chk("wrap_fetch_seq", 100 + c, {6'b0, imem_addr}, {6'b0, W'(prev_addr + 1'b1)});
               else chk("wrap_first_fetch", 100 + c, {6'b0, imem_addr}, 16'h03fe);
               have_prev = 1'b1;
               prev_addr = imem_addr;
            end
            if (instr_valid) begin
               started = 1'b1;
               chk("wrap_instr", 100 + c, instr_out, exp_q.pop_front());
               chk("wrap_pc", 100 + c, {6'b0, instr_pc}, {6'b0, exp_pc_q.pop_front()});
            end else if (started) begin
               chk("wrap_gap", 100 + c, 16'h0000, 16'h0001);
            end
         end
         if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL wrap_timeout: got %0d outputs still pending want 0", exp_q.size());
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pl_fetch_unit.md
PL_FETCH_UNIT -- requirements
Module: pl_fetch_unit

Interface
REQ-001 Parameter PROG_CTR_WID, default 10, program counter and instruction address width in bits.
REQ-002 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 stall  in  1  decode-stage hold request; output instruction SHALL be frozen while high.
REQ-005 branch_taken_reg  in  1  redirect strobe from the execute stage.
REQ-006 branch_target  in  PROG_CTR_WID  redirect address, sampled when branch_taken_reg=1.
REQ-007 imem_rd_en  out  1  instruction memory read request.
REQ-008 imem_addr  out  PROG_CTR_WID  read address, valid when imem_rd_en=1.
REQ-009 imem_rdata  in  16  read data, valid exactly one cycle after the matching imem_rd_en.
REQ-010 instr_out  out  16  registered instruction to decode; 16'h0000 (NOP) when not valid.
REQ-011 instr_valid  out  1  instr_out holds a real fetched instruction.
REQ-012 instr_pc  out  PROG_CTR_WID  address of instr_out.

Function
REQ-013 FSM states: RST_WAIT, RUN, FLUSH; RST_WAIT -> RUN after one cycle; RUN -> FLUSH on branch_taken_reg=1; FLUSH -> RUN after one cycle; branch_taken_reg=1 in FLUSH SHALL restart FLUSH with the new target.
REQ-014 Internal state: pc, 2-entry FIFO of {instr, addr}, fifo_count (0..2), inflight flag, inflight_addr.
REQ-015 In RUN, a request SHALL issue iff branch_taken_reg=0 and registered fifo_count + inflight <= 1; on issue imem_rd_en=1, imem_addr=pc, pc <= pc+1 modulo 2^PROG_CTR_WID.
REQ-016 No request SHALL issue in RST_WAIT or FLUSH, or in the cycle branch_taken_reg=1.
REQ-017 Cycle after an issue: inflight=1 and imem_rdata SHALL be captured with inflight_addr, unless dropped per REQ-021.
REQ-018 Output update when stall=0: if FIFO non-empty, head moves to instr_out/instr_pc, instr_valid=1, captured response (if any) enqueued; else if response captured this cycle, it SHALL bypass directly to the output; else instr_out=0, instr_valid=0.
REQ-019 When stall=1: instr_out, instr_valid, instr_pc SHALL hold; captured responses enqueue into the FIFO; FIFO SHALL never overflow (guaranteed by REQ-015).
REQ-020 Simultaneous enqueue and dequeue SHALL keep fifo_count unchanged and preserve order.
REQ-021 branch_taken_reg=1 (priority over stall): pc <= branch_target, FIFO cleared, any response arriving that cycle or the next dropped, instr_out <= 0, instr_valid <= 0, instr_pc <= 0.
REQ-022 Redirect latency: branch at cycle T -> imem_rd_en with imem_addr=branch_target at T+2 (T+1 is FLUSH), instr_valid=1 with instr_pc=branch_target at T+4 when stall=0.
REQ-023 Steady state with stall=0 SHALL deliver one valid instruction per cycle, addresses strictly consecutive.

Reset
REQ-024 rst=1 SHALL set pc=0, fifo_count=0, inflight=0, state RST_WAIT, imem_rd_en=0, imem_addr=0, instr_out=0, instr_valid=0, instr_pc=0.
REQ-025 rst mid-operation SHALL discard FIFO contents and any in-flight response; first request after rst release SHALL address 0.
REQ-026 rst SHALL take priority over branch_taken_reg and stall.

Verification
REQ-027 Release reset, stall=0, memory returns addr+16'h1000 -> first imem_rd_en addr 0 one cycle after release; instr_valid rises two cycles later with instr_out=16'h1000, then 16'h1001, 16'h1002 on consecutive cycles.
REQ-028 Stall held 5 cycles during streaming -> instr_out frozen; at most 2 further requests issued; on release the next two outputs are the buffered addresses in order, no gaps, no duplicates.
REQ-029 branch_taken_reg=1, target 10'h155, while FIFO holds 2 entries and stall=1 -> instr_valid=0 next cycle; old entries never appear; imem_addr=10'h155 at T+2; instr_pc=10'h155 valid at T+4.
REQ-030 pc at 10'h3FF, stall=0 -> fetch 10'h3FF then 10'h000, outputs consecutive across wrap.
REQ-031 Back-to-back branches at T and T+1 (targets 10'h020, 10'h040) -> no fetch of 10'h020 observed; first valid instr_pc=10'h040.
REQ-032 rst asserted for one cycle mid-stream with 2 FIFO entries -> all outputs zero next cycle; subsequent stream restarts at address 0.
